// File: rtl/ex_stage_muldiv.sv
// Execute stage: forwarding muxes, ALU, branch target, destination select,
// and an iterative multiply/divide unit with HI/LO and a hazard stall request.
module ex_stage_muldiv #(
   parameter int WIDTH          = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LINK_REGISTER  = 31
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          pc_4,
   input  logic [31:0]               instruction,
   input  logic [4:0]                aluOperation,
   input  logic                      shouldAluUseShiftAmountElseRegisterRs,
   input  logic                      shouldAluUseImmeidateElseRegisterRt,
   input  logic                      isJumpAndLink,
   input  logic                      shouldWriteToRegisterRtElseRd,
   input  logic [WIDTH-1:0]          shiftAmount,
   input  logic [WIDTH-1:0]          immediate,
   input  logic [WIDTH-1:0]          registerRs,
   input  logic [WIDTH-1:0]          registerRt,
   input  logic [1:0]                forwardRsSelect,
   input  logic [1:0]                forwardRtSelect,
   input  logic [WIDTH-1:0]          memForwardData,
   input  logic [WIDTH-1:0]          wbForwardData,
   input  logic                      shouldStall,
   input  logic                      mdStart,
   input  logic [1:0]                mdOperation,
   input  logic                      mdCancel,
   input  logic [1:0]                resultSelect,
   output logic [REG_ADDR_WIDTH-1:0] registerWriteAddress,
   output logic [WIDTH-1:0]          result,
   output logic                      isResultZero,
   output logic [WIDTH-1:0]          branchPc,
   output logic                      mdBusy,
   output logic                      mdStallRequest,
   output logic [WIDTH-1:0]          hi,
   output logic [WIDTH-1:0]          lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdState_e;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } aluOp_e;

   logic [WIDTH-1:0]   fwdRs, fwdRt, aluA, aluB, aluResult;
   mdState_e           state, nextState;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   accHi, accLo, opB, magA, magB;
   logic               signQp, signRem, opIsDiv, signA, signB, accept;
   logic [WIDTH:0]     mulSum, divShift;
   logic [WIDTH+1:0]   divDiff;
   logic [2*WIDTH-1:0] fixProduct;
   logic               unusedBits;

   assign unusedBits = ^{instruction[31:21], instruction[10:0], divDiff[WIDTH]};

   // Operand forwarding from MEM/WB, then ALU operand selection
   always_comb begin
      case (forwardRsSelect)
         2'b01:   fwdRs = memForwardData;
         2'b10:   fwdRs = wbForwardData;
         default: fwdRs = registerRs;
      endcase
      case (forwardRtSelect)
         2'b01:   fwdRt = memForwardData;
         2'b10:   fwdRt = wbForwardData;
         default: fwdRt = registerRt;
      endcase
      aluA = shouldAluUseShiftAmountElseRegisterRs ? shiftAmount : fwdRs;
      aluB = shouldAluUseImmeidateElseRegisterRt ? immediate : fwdRt;
   end

   // ALU: shifts take A as the amount and B as the value
   always_comb begin
      aluResult = '0;
      case (aluOp_e'(aluOperation))
         ALU_ADD:  aluResult = aluA + aluB;
         ALU_SUB:  aluResult = aluA - aluB;
         ALU_AND:  aluResult = aluA & aluB;
         ALU_OR:   aluResult = aluA | aluB;
         ALU_XOR:  aluResult = aluA ^ aluB;
         ALU_NOR:  aluResult = ~(aluA | aluB);
         ALU_SLT:  aluResult[0] = $signed(aluA) < $signed(aluB);
         ALU_SLTU: aluResult[0] = aluA < aluB;
         ALU_SLL:  aluResult = aluB << aluA[CW-1:0];
         ALU_SRL:  aluResult = aluB >> aluA[CW-1:0];
         ALU_SRA:  aluResult = $signed(aluB) >>> aluA[CW-1:0];
         ALU_LUI:  aluResult = {aluB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default:  aluResult = '0;
      endcase
   end

   // Destination register, branch target and stage result
   always_comb begin
      if (isJumpAndLink)
         registerWriteAddress = REG_ADDR_WIDTH'(LINK_REGISTER);
      else if (shouldWriteToRegisterRtElseRd)
         registerWriteAddress = REG_ADDR_WIDTH'(instruction[20:16]);
      else
         registerWriteAddress = REG_ADDR_WIDTH'(instruction[15:11]);
      branchPc = pc_4 + (immediate << 2);
      case (resultSelect)
         2'b01:   result = hi;
         2'b10:   result = lo;
         default: result = aluResult;
      endcase
      isResultZero = (result == '0);
   end

   // Mul/div acceptance, operand magnitudes and per-cycle datapath terms
   always_comb begin
      mdBusy         = (state != IDLE);
      mdStallRequest = mdBusy & (mdStart | (resultSelect == 2'b01) | (resultSelect == 2'b10));
      accept         = mdStart & ~shouldStall & ~mdCancel & (state == IDLE);
      signA          = mdOperation[0] & fwdRs[WIDTH-1];
      signB          = mdOperation[0] & fwdRt[WIDTH-1];
      magA           = signA ? -fwdRs : fwdRs;
      magB           = signB ? -fwdRt : fwdRt;
      mulSum         = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
      divShift       = {accHi, accLo[WIDTH-1]};
      divDiff        = {1'b0, divShift} - {2'b00, opB};
      fixProduct     = signQp ? -{accHi, accLo} : {accHi, accLo};
   end

   // Mul/div state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Mul/div next state; cancel wins from any state
   always_comb begin
      nextState = state;
      if (mdCancel) nextState = IDLE;
      else begin
         case (state)
            IDLE:    if (accept) nextState = mdOperation[1] ? DIV : MUL;
            MUL,
            DIV:     if (count == '0) nextState = FIX;
            default: nextState = IDLE;
         endcase
      end
   end

   // Mul/div datapath and HI/LO write-back
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count   <= '0;
         accHi   <= '0;
         accLo   <= '0;
         opB     <= '0;
         signQp  <= 1'b0;
         signRem <= 1'b0;
         opIsDiv <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               count   <= CW'(WIDTH - 1);
               accHi   <= '0;
               accLo   <= magA;
               opB     <= magB;
               signQp  <= signA ^ signB;
               signRem <= signA;
               opIsDiv <= mdOperation[1];
            end
            MUL: begin
               accHi <= mulSum[WIDTH:1];
               accLo <= {mulSum[0], accLo[WIDTH-1:1]};
               count <= count - 1'b1;
            end
            DIV: begin
               if (!divDiff[WIDTH+1]) begin
                  accHi <= divDiff[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b1};
               end else begin
                  accHi <= divShift[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b0};
               end
               count <= count - 1'b1;
            end
            default: if (!mdCancel) begin
               if (opIsDiv) begin
                  // With a zero divisor the remainder equals the dividend magnitude,
                  // so re-applying the dividend sign restores the original bits.
                  hi <= signRem ? -accHi : accHi;
                  if (opB == '0) lo <= '1;
                  else           lo <= signQp ? -accLo : accLo;
               end else begin
                  {hi, lo} <= fixProduct;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed self-checking bench for ex_stage_muldiv.
module tb_ex_stage_muldiv;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc_4, instruction, shiftAmount, immediate, registerRs, registerRt;
   logic [31:0] memForwardData, wbForwardData;
   logic [4:0]  aluOperation;
   logic        useShamt, useImm, isJumpAndLink, rtElseRd;
   logic [1:0]  forwardRsSelect, forwardRtSelect, mdOperation, resultSelect;
   logic        shouldStall, mdStart, mdCancel;
   logic [4:0]  registerWriteAddress;
   logic [31:0] result, branchPc, hi, lo;
   logic        isResultZero, mdBusy, mdStallRequest;

   int compared = 0;
   int mismatched = 0;

   ex_stage_muldiv #(.WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_REGISTER(31)) dut (
      .clock(clock), .reset(reset), .pc_4(pc_4), .instruction(instruction),
      .aluOperation(aluOperation),
      .shouldAluUseShiftAmountElseRegisterRs(useShamt),
      .shouldAluUseImmeidateElseRegisterRt(useImm),
      .isJumpAndLink(isJumpAndLink), .shouldWriteToRegisterRtElseRd(rtElseRd),
      .shiftAmount(shiftAmount), .immediate(immediate),
      .registerRs(registerRs), .registerRt(registerRt),
      .forwardRsSelect(forwardRsSelect), .forwardRtSelect(forwardRtSelect),
      .memForwardData(memForwardData), .wbForwardData(wbForwardData),
      .shouldStall(shouldStall), .mdStart(mdStart), .mdOperation(mdOperation),
      .mdCancel(mdCancel), .resultSelect(resultSelect),
      .registerWriteAddress(registerWriteAddress), .result(result),
      .isResultZero(isResultZero), .branchPc(branchPc), .mdBusy(mdBusy),
      .mdStallRequest(mdStallRequest), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   // Launch one mul/div operation; returns one time unit after the accept edge
   task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      forwardRsSelect = 2'b00; forwardRtSelect = 2'b00;
      registerRs = a; registerRt = b; mdOperation = op; mdStart = 1'b1;
      @(posedge clock); #1;
      mdStart = 1'b0;
   endtask

   // Count busy cycles until idle, bounded
   task automatic waitIdle(output int n);
      n = 0;
      while (mdBusy && n < 200) begin
         @(posedge clock); #1; n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clock); #1;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", mdBusy); end
      compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL reset_hi: got %h want 0", hi); end
      compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL reset_lo: got %h want 0", lo); end
      compared++; if (mdStallRequest !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", mdStallRequest); end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_forward_alu;
      registerRs = 32'd9; memForwardData = 32'd5; forwardRsSelect = 2'b01;
      immediate = 32'd3; useImm = 1'b1; aluOperation = 5'd0; resultSelect = 2'b00; #1;
      compared++; if (result !== 32'd8) begin mismatched++; $display("FAIL fwd_add: got %h want 8", result); end
      compared++; if (isResultZero !== 1'b0) begin mismatched++; $display("FAIL fwd_add_zero: got %b want 0", isResultZero); end
      isJumpAndLink = 1'b1; #1;
      compared++; if (registerWriteAddress !== 5'd31) begin mismatched++; $display("FAIL jal_addr: got %0d want 31", registerWriteAddress); end
      isJumpAndLink = 1'b0; instruction = {6'h0, 5'd3, 5'd7, 5'd12, 11'h0}; rtElseRd = 1'b1; #1;
      compared++; if (registerWriteAddress !== 5'd7) begin mismatched++; $display("FAIL rt_addr: got %0d want 7", registerWriteAddress); end
      rtElseRd = 1'b0; #1;
      compared++; if (registerWriteAddress !== 5'd12) begin mismatched++; $display("FAIL rd_addr: got %0d want 12", registerWriteAddress); end
      pc_4 = 32'h100; immediate = 32'hFFFF_FFFF; #1;
      compared++; if (branchPc !== 32'hFC) begin mismatched++; $display("FAIL branch_pc: got %h want 000000fc", branchPc); end
      forwardRsSelect = 2'b00; registerRs = 32'd20; forwardRtSelect = 2'b10; wbForwardData = 32'd20;
      registerRt = 32'd99; useImm = 1'b0; aluOperation = 5'd1; #1;
      compared++; if (result !== 32'd0) begin mismatched++; $display("FAIL fwd_sub: got %h want 0", result); end
      compared++; if (isResultZero !== 1'b1) begin mismatched++; $display("FAIL fwd_sub_zero: got %b want 1", isResultZero); end
      forwardRtSelect = 2'b00; aluOperation = 5'd0;
   endtask

   task automatic test_multu;
      int n;
      startOp(2'b00, 32'hFFFF_FFFF, 32'h2);
      waitIdle(n);
      compared++; if (n !== 33) begin mismatched++; $display("FAIL multu_latency: got %0d want 33", n); end
      compared++; if (hi !== 32'h1) begin mismatched++; $display("FAIL multu_hi: got %h want 00000001", hi); end
      compared++; if (lo !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
   endtask

   task automatic test_signed;
      int n;
      startOp(2'b01, -32'sd3, 32'd5);
      waitIdle(n);
      compared++; if (n !== 33) begin mismatched++; $display("FAIL mult_latency: got %0d want 33", n); end
      compared++; if (hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      compared++; if (lo !== 32'hFFFF_FFF1) begin mismatched++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
      startOp(2'b11, -32'sd7, 32'd2);
      waitIdle(n);
      compared++; if (n !== 33) begin mismatched++; $display("FAIL div_latency: got %0d want 33", n); end
      compared++; if (lo !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      compared++; if (hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_hi: got %h want ffffffff", hi); end
   endtask

   task automatic test_special;
      int n;
      startOp(2'b10, 32'h1234, 32'h0);
      waitIdle(n);
      compared++; if (n !== 33) begin mismatched++; $display("FAIL divu0_latency: got %0d want 33", n); end
      compared++; if (hi !== 32'h1234) begin mismatched++; $display("FAIL divu0_hi: got %h want 00001234", hi); end
      compared++; if (lo !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
      startOp(2'b11, -32'sd7, 32'h0);
      waitIdle(n);
      compared++; if (hi !== 32'hFFFF_FFF9) begin mismatched++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
      compared++; if (lo !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
      startOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(n);
      compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL divovf_hi: got %h want 0", hi); end
      compared++; if (lo !== 32'h8000_0000) begin mismatched++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
      startOp(2'b01, 32'h8000_0000, 32'h8000_0000);
      waitIdle(n);
      compared++; if (hi !== 32'h4000_0000) begin mismatched++; $display("FAIL multmin_hi: got %h want 40000000", hi); end
      compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL multmin_lo: got %h want 0", lo); end
   endtask

   task automatic test_mflo_stall;
      int n;
      resultSelect = 2'b00; registerRs = 32'd6; registerRt = 32'd7;
      mdOperation = 2'b00; mdStart = 1'b1; #1;
      compared++; if (mdStallRequest !== 1'b0) begin mismatched++; $display("FAIL stall_idle_start: got %b want 0", mdStallRequest); end
      @(posedge clock); #1;
      mdStart = 1'b0; resultSelect = 2'b10; #1;
      n = 0;
      while (mdStallRequest && n < 200) begin
         @(posedge clock); #1; n++;
      end
      compared++; if (n !== 33) begin mismatched++; $display("FAIL mflo_stall_cycles: got %0d want 33", n); end
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL mflo_busy_end: got %b want 0", mdBusy); end
      compared++; if (result !== 32'd42) begin mismatched++; $display("FAIL mflo_result: got %h want 0000002a", result); end
      compared++; if (isResultZero !== 1'b0) begin mismatched++; $display("FAIL mflo_zero: got %b want 0", isResultZero); end
      resultSelect = 2'b01; #1;
      compared++; if (result !== 32'd0) begin mismatched++; $display("FAIL mfhi_result: got %h want 0", result); end
      compared++; if (isResultZero !== 1'b1) begin mismatched++; $display("FAIL mfhi_zero: got %b want 1", isResultZero); end
      resultSelect = 2'b00;
   endtask

   task automatic test_back_to_back;
      int n;
      startOp(2'b00, 32'd6, 32'd7);
      registerRs = 32'd45; registerRt = 32'd4; mdOperation = 2'b10; mdStart = 1'b1; #1;
      n = 0;
      while (mdStallRequest && n < 200) begin
         @(posedge clock); #1; n++;
      end
      compared++; if (n !== 33) begin mismatched++; $display("FAIL b2b_start_stall: got %0d want 33", n); end
      compared++; if (lo !== 32'd42) begin mismatched++; $display("FAIL b2b_first_lo: got %h want 0000002a", lo); end
      @(posedge clock); #1;
      mdStart = 1'b0;
      compared++; if (mdBusy !== 1'b1) begin mismatched++; $display("FAIL b2b_second_accept: got %b want 1", mdBusy); end
      waitIdle(n);
      compared++; if (lo !== 32'd11) begin mismatched++; $display("FAIL b2b_divu_lo: got %h want 0000000b", lo); end
      compared++; if (hi !== 32'd1) begin mismatched++; $display("FAIL b2b_divu_hi: got %h want 00000001", hi); end
   endtask

   task automatic test_hold_start;
      int n;
      registerRs = 32'd100; registerRt = 32'd7; mdOperation = 2'b10;
      mdStart = 1'b1; shouldStall = 1'b1;
      repeat (2) @(posedge clock); #1;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL stalled_start: got %b want 0", mdBusy); end
      shouldStall = 1'b0;
      @(posedge clock); #1;
      mdStart = 1'b0; shouldStall = 1'b1;
      waitIdle(n);
      shouldStall = 1'b0;
      compared++; if (n !== 33) begin mismatched++; $display("FAIL stall_no_pause: got %0d want 33", n); end
      compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL hold_divu_lo: got %h want 0000000e", lo); end
      compared++; if (hi !== 32'd2) begin mismatched++; $display("FAIL hold_divu_hi: got %h want 00000002", hi); end
   endtask

   task automatic test_cancel;
      startOp(2'b11, -32'sd100, 32'd7);
      repeat (9) @(posedge clock); #1;
      compared++; if (mdBusy !== 1'b1) begin mismatched++; $display("FAIL cancel_pre_busy: got %b want 1", mdBusy); end
      mdCancel = 1'b1; mdStart = 1'b1;
      @(posedge clock); #1;
      mdCancel = 1'b0; mdStart = 1'b0;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL cancel_idle: got %b want 0", mdBusy); end
      compared++; if (hi !== 32'd2) begin mismatched++; $display("FAIL cancel_hi: got %h want 00000002", hi); end
      compared++; if (lo !== 32'd14) begin mismatched++; $display("FAIL cancel_lo: got %h want 0000000e", lo); end
      mdCancel = 1'b1; mdStart = 1'b1;
      @(posedge clock); #1;
      mdCancel = 1'b0; mdStart = 1'b0;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL cancel_blocks_start: got %b want 0", mdBusy); end
   endtask

   task automatic test_reset_mid;
      startOp(2'b00, 32'hFFFF, 32'hFFFF);
      repeat (5) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b want 0", mdBusy); end
      compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL midreset_hi: got %h want 0", hi); end
      compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL midreset_lo: got %h want 0", lo); end
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      compared++; if (mdBusy !== 1'b0) begin mismatched++; $display("FAIL postreset_busy: got %b want 0", mdBusy); end
   endtask

   initial begin
      reset = 1'b1; pc_4 = '0; instruction = '0; shiftAmount = '0; immediate = '0;
      registerRs = '0; registerRt = '0; memForwardData = '0; wbForwardData = '0;
      aluOperation = '0; useShamt = 1'b0; useImm = 1'b0; isJumpAndLink = 1'b0; rtElseRd = 1'b0;
      forwardRsSelect = '0; forwardRtSelect = '0; mdOperation = '0; resultSelect = '0;
      shouldStall = 1'b0; mdStart = 1'b0; mdCancel = 1'b0;
      test_reset;
      test_forward_alu;
      test_multu;
      test_signed;
      test_special;
      test_mflo_stall;
      test_back_to_back;
      test_hold_start;
      test_cancel;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1);
   end

endmodule
